// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: opcodes, NOP and the inter-stage bundles.
package mips_pkg;
  localparam int XLEN  = 32;
  localparam int ALU_W = 3;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;

  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  typedef struct packed {
    logic [5:0]       op_code;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       wr_addr;
    logic             wr_en;
    logic [1:0]       wr_sel;
    logic             mem_write;
    logic [ALU_W-1:0] alu_ctrl;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  sign_imm;
    logic             valid;
  } id_ex_t;

  localparam if_id_t IF_ID_NOP = '{
    instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0
  };

  // Bubble: R_TYPE opcode with no writes, so it never looks like a load.
  localparam id_ex_t ID_EX_BUBBLE = '{
    op_code: R_TYPE, rs: '0, rt: '0, rd: '0,
    wr_addr: '0, wr_en: 1'b0, wr_sel: '0,
    mem_write: 1'b0, alu_ctrl: '0, rd1: '0,
    rd2: '0, sign_imm: '0, valid: 1'b0
  };
endpackage

// File: rtl/pipe_front_regs_if.sv
// Hazard-unit control into the front-end registers (stall/flush/redirect).
interface pipe_front_regs_if;
  logic stall_f;
  logic stall_d;
  logic flush_e;
  logic branch_taken_d;
  logic jump_d;

  modport master (
    output stall_f, stall_d, flush_e,
    output branch_taken_d, jump_d
  );

  modport slave (
    input stall_f, stall_d, flush_e,
    input branch_taken_d, jump_d
  );
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: enable, sync clear, async active-low reset.
module pipe_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  // Enable gates the clear too: a held stage ignores a clear request.
  always_comb begin
    q_d = q_q;
    if (en) q_d = clr ? CLR_VAL : d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS core.
// PIPE_FRONT_PERF_CNT_EN adds saturating stall/bubble counters.
module pipe_front_regs
  import mips_pkg::*;
#(
  parameter int              DATA_W     = XLEN,
  parameter logic [XLEN-1:0] PC_RESET   = 32'h0000_0000,
  parameter int              ALU_CTRL_W = ALU_W
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_front_regs_if.slave      hz,
  input  logic [DATA_W-1:0]     pc_next_f,
  input  logic [DATA_W-1:0]     instr_f,
  input  logic [5:0]            op_code_d,
  input  logic [4:0]            rs_d,
  input  logic [4:0]            rt_d,
  input  logic [4:0]            rd_d,
  input  logic [4:0]            reg_file_write_addr_d,
  input  logic                  reg_write_enable_d,
  input  logic [1:0]            reg_write_data_sel_d,
  input  logic                  mem_write_d,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl_d,
  input  logic [DATA_W-1:0]     rd1_d,
  input  logic [DATA_W-1:0]     rd2_d,
  input  logic [DATA_W-1:0]     sign_imm_d,
  output logic [DATA_W-1:0]     pc_f,
  output logic [DATA_W-1:0]     instr_d,
  output logic [DATA_W-1:0]     pc_plus4_d,
  output logic                  valid_d,
  output logic                  valid_e,
  output logic [5:0]            op_code_e,
  output logic [4:0]            rs_e,
  output logic [4:0]            rt_e,
  output logic [4:0]            rd_e,
  output logic [4:0]            reg_file_write_addr_e,
  output logic                  reg_write_enable_e,
  output logic                  mem_write_e,
  output logic [1:0]            reg_write_data_sel_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic [DATA_W-1:0]     rd1_e,
  output logic [DATA_W-1:0]     rd2_e,
  output logic [DATA_W-1:0]     sign_imm_e
`ifdef PIPE_FRONT_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cycles
`endif
);
  logic [XLEN-1:0] pc_d, pc_q;
  if_id_t          if_id_d, if_id_q;
  id_ex_t          id_ex_d, id_ex_q;
  logic            redirect;

  assign redirect = hz.branch_taken_d | hz.jump_d;

  always_comb begin
    pc_d    = pc_next_f;
    if_id_d = '{
      instr:    instr_f,
      pc_plus4: pc_q + XLEN'(4),
      valid:    1'b1
    };
    id_ex_d = '{
      op_code:   op_code_d,
      rs:        rs_d,
      rt:        rt_d,
      rd:        rd_d,
      wr_addr:   reg_file_write_addr_d,
      wr_en:     reg_write_enable_d,
      wr_sel:    reg_write_data_sel_d,
      mem_write: mem_write_d,
      alu_ctrl:  alu_ctrl_d,
      rd1:       rd1_d,
      rd2:       rd2_d,
      sign_imm:  sign_imm_d,
      valid:     if_id_q.valid
    };
  end

  pipe_reg #(
    .WIDTH   (XLEN),
    .RST_VAL (PC_RESET)
  ) u_pc (
    .clk   (clk),
    .rst_n (reset),
    .en    (~hz.stall_f),
    .clr   (1'b0),
    .d     (pc_d),
    .q     (pc_q)
  );

  // Stall wins over redirect: the branch is re-resolved once unstalled.
  pipe_reg #(
    .WIDTH   ($bits(if_id_t)),
    .CLR_VAL (IF_ID_NOP)
  ) u_if_id (
    .clk   (clk),
    .rst_n (reset),
    .en    (~hz.stall_d),
    .clr   (redirect),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  pipe_reg #(
    .WIDTH   ($bits(id_ex_t)),
    .CLR_VAL (ID_EX_BUBBLE)
  ) u_id_ex (
    .clk   (clk),
    .rst_n (reset),
    .en    (1'b1),
    .clr   (hz.flush_e),
    .d     (id_ex_d),
    .q     (id_ex_q)
  );

  assign pc_f                  = pc_q;
  assign instr_d               = if_id_q.instr;
  assign pc_plus4_d            = if_id_q.pc_plus4;
  assign valid_d               = if_id_q.valid;
  assign valid_e               = id_ex_q.valid;
  assign op_code_e             = id_ex_q.op_code;
  assign rs_e                  = id_ex_q.rs;
  assign rt_e                  = id_ex_q.rt;
  assign rd_e                  = id_ex_q.rd;
  assign reg_file_write_addr_e = id_ex_q.wr_addr;
  assign reg_write_enable_e    = id_ex_q.wr_en;
  assign mem_write_e           = id_ex_q.mem_write;
  assign reg_write_data_sel_e  = id_ex_q.wr_sel;
  assign alu_ctrl_e            = id_ex_q.alu_ctrl;
  assign rd1_e                 = id_ex_q.rd1;
  assign rd2_e                 = id_ex_q.rd2;
  assign sign_imm_e            = id_ex_q.sign_imm;

`ifdef PIPE_FRONT_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic        bubble_load;

  // Any ID/EX load that leaves valid_e low counts, flush or NOP alike.
  assign bubble_load = hz.flush_e | ~if_id_q.valid;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hz.stall_d && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (bubble_load && bubble_cnt_q != '1)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign bubble_cycles = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: expected state queued per drive.
module tb_pipe_front_regs;
  import mips_pkg::*;

  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  pipe_front_regs_if hz ();

  logic [31:0] pc_next_f, instr_f;
  logic [5:0]  op_code_d;
  logic [4:0]  rs_d, rt_d, rd_d, wa_d;
  logic        we_d, mw_d;
  logic [1:0]  wds_d;
  logic [2:0]  alu_d;
  logic [31:0] rd1_d, rd2_d, imm_d;

  logic [31:0] pc_f, instr_d, pc_plus4_d;
  logic        valid_d, valid_e;
  logic [5:0]  op_code_e;
  logic [4:0]  rs_e, rt_e, rd_e, wa_e;
  logic        we_e, mw_e;
  logic [1:0]  wds_e;
  logic [2:0]  alu_e;
  logic [31:0] rd1_e, rd2_e, imm_e;
  logic [31:0] stall_cycles, bubble_cycles;

  pipe_front_regs #(
    .PC_RESET (PC_RST)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .hz                    (hz),
    .pc_next_f             (pc_next_f),
    .instr_f               (instr_f),
    .op_code_d             (op_code_d),
    .rs_d                  (rs_d),
    .rt_d                  (rt_d),
    .rd_d                  (rd_d),
    .reg_file_write_addr_d (wa_d),
    .reg_write_enable_d    (we_d),
    .reg_write_data_sel_d  (wds_d),
    .mem_write_d           (mw_d),
    .alu_ctrl_d            (alu_d),
    .rd1_d                 (rd1_d),
    .rd2_d                 (rd2_d),
    .sign_imm_d            (imm_d),
    .pc_f                  (pc_f),
    .instr_d               (instr_d),
    .pc_plus4_d            (pc_plus4_d),
    .valid_d               (valid_d),
    .valid_e               (valid_e),
    .op_code_e             (op_code_e),
    .rs_e                  (rs_e),
    .rt_e                  (rt_e),
    .rd_e                  (rd_e),
    .reg_file_write_addr_e (wa_e),
    .reg_write_enable_e    (we_e),
    .mem_write_e           (mw_e),
    .reg_write_data_sel_e  (wds_e),
    .alu_ctrl_e            (alu_e),
    .rd1_e                 (rd1_e),
    .rd2_e                 (rd2_e),
    .sign_imm_e            (imm_e)
`ifdef PIPE_FRONT_PERF_CNT_EN
    ,
    .stall_cycles          (stall_cycles),
    .bubble_cycles         (bubble_cycles)
`endif
  );

`ifndef PIPE_FRONT_PERF_CNT_EN
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
`endif

  logic [128:0] ex_obs, dec_vec;
  assign ex_obs  = {op_code_e, rs_e, rt_e, rd_e, wa_e, we_e,
                    wds_e, mw_e, alu_e, rd1_e, rd2_e, imm_e};
  assign dec_vec = {op_code_d, rs_d, rt_d, rd_d, wa_d, we_d,
                    wds_d, mw_d, alu_d, rd1_d, rd2_d, imm_d};

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [31:0]  pp4;
    logic         vd;
    logic         ve;
    logic [128:0] ex;
    logic [31:0]  sc;
    logic [31:0]  bc;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0]  m_pc, m_instr, m_pp4, m_sc, m_bc;
  logic         m_vd, m_ve;
  logic [128:0] m_ex;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = PC_RST;
    m_instr = '0;
    m_pp4   = '0;
    m_vd    = 1'b0;
    m_ve    = 1'b0;
    m_ex    = '0;
    m_sc    = '0;
    m_bc    = '0;
  endtask

  task automatic compare_now(input exp_t e, input string ph);
    check({ph, " pc_f"}, 256'(pc_f), 256'(e.pc));
    check({ph, " instr_d"}, 256'(instr_d), 256'(e.instr));
    check({ph, " pc_plus4_d"}, 256'(pc_plus4_d), 256'(e.pp4));
    check({ph, " valid_d"}, 256'(valid_d), 256'(e.vd));
    check({ph, " valid_e"}, 256'(valid_e), 256'(e.ve));
    check({ph, " id_ex"}, 256'(ex_obs), 256'(e.ex));
`ifdef PIPE_FRONT_PERF_CNT_EN
    check({ph, " stall_cycles"}, 256'(stall_cycles), 256'(e.sc));
    check({ph, " bubble_cycles"}, 256'(bubble_cycles), 256'(e.bc));
`endif
  endtask

  // Starts and ends on a falling edge; one rising edge in between.
  task automatic step(input logic sf, input logic sd, input logic fe,
                      input logic br, input logic jp,
                      input logic [5:0] op);
    exp_t e;
    logic nve;
    hz.stall_f        = sf;
    hz.stall_d        = sd;
    hz.flush_e        = fe;
    hz.branch_taken_d = br;
    hz.jump_d         = jp;
    pc_next_f = (br | jp) ? 32'h1000 + 32'($urandom_range(0, 255)) * 4
                          : m_pc + 32'd4;
    instr_f   = $urandom;
    op_code_d = op;
    rs_d  = 5'($urandom);
    rt_d  = 5'($urandom);
    rd_d  = 5'($urandom);
    wa_d  = 5'($urandom);
    we_d  = 1'($urandom);
    mw_d  = 1'($urandom);
    wds_d = 2'($urandom);
    alu_d = 3'($urandom);
    rd1_d = $urandom;
    rd2_d = $urandom;
    imm_d = $urandom;
    #0;
    nve  = fe ? 1'b0 : m_vd;
    m_ex = fe ? '0 : dec_vec;
    m_ve = nve;
    if (sd && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (!nve && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    if (!sd) begin
      if (br | jp) begin
        m_instr = '0;
        m_pp4   = '0;
        m_vd    = 1'b0;
      end else begin
        m_instr = instr_f;
        m_pp4   = m_pc + 32'd4;
        m_vd    = 1'b1;
      end
    end
    if (!sf) m_pc = pc_next_f;
    e = '{pc: m_pc, instr: m_instr, pp4: m_pp4, vd: m_vd,
          ve: m_ve, ex: m_ex, sc: m_sc, bc: m_bc};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard empty", 256'(0), 256'(1));
    end else begin
      e = sb_q.pop_front();
      compare_now(e, "step");
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, R_TYPE);
  endtask

  task automatic async_reset_pulse();
    exp_t e;
    #1 reset = 1'b0;
    #1;
    model_reset();
    e = '{pc: m_pc, instr: m_instr, pp4: m_pp4, vd: m_vd,
          ve: m_ve, ex: m_ex, sc: m_sc, bc: m_bc};
    compare_now(e, "async_rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b0;
    hz.stall_f = 0; hz.stall_d = 0; hz.flush_e = 0;
    hz.branch_taken_d = 0; hz.jump_d = 0;
    pc_next_f = '0; instr_f = '0; op_code_d = '0;
    rs_d = '0; rt_d = '0; rd_d = '0; wa_d = '0;
    we_d = 0; mw_d = 0; wds_d = '0; alu_d = '0;
    rd1_d = '0; rd2_d = '0; imm_d = '0;
    model_reset();
    #12;
    e = '{pc: PC_RST, instr: '0, pp4: '0, vd: 1'b0,
          ve: 1'b0, ex: '0, sc: '0, bc: '0};
    compare_now(e, "reset");
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch: pc 4, 8, 12; valid ripples into ID then EX.
    run(3);

    // Load-use: LW in decode, dependent ADD held one cycle.
    step(0, 0, 0, 0, 0, LW);
    step(1, 1, 1, 0, 0, R_TYPE);
    check("loaduse op_code_e", 256'(op_code_e), 256'(R_TYPE));
    check("loaduse we_e", 256'(we_e), 256'(0));
    run(2);

    // Taken branch, no stall.
    step(0, 0, 0, 1, 0, BEQ);
    check("beq clear instr_d", 256'(instr_d), 256'(NOP_INSTR));
    run(2);

    // Taken branch pending under a 2-cycle stall.
    step(1, 1, 1, 1, 0, BEQ);
    step(1, 1, 1, 1, 0, BEQ);
    step(0, 0, 0, 1, 0, BEQ);
    run(2);

    // Jump and flush together.
    step(0, 0, 1, 0, 1, J);
    run(2);

    // Reset mid-stream, then 3 stalls plus one redirect.
    async_reset_pulse();
    run(2);
    step(1, 1, 1, 0, 0, ADDI);
    step(1, 1, 1, 0, 0, ADDI);
    step(1, 1, 1, 0, 0, ADDI);
    step(0, 0, 0, 1, 0, BEQ);
    run(2);

    for (int i = 0; i < 40; i++) begin
      logic s, f, b, j;
      s = ($urandom_range(0, 3) == 0);
      f = s | ($urandom_range(0, 5) == 0);
      b = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 7) == 0);
      step(s, s, f, b, j, 6'($urandom));
    end

    async_reset_pulse();
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
